// File: rtl/sdp_pkg.sv
// Shared types and sizing for the SDP result collector slice.
//   SDP_DATA_W     : result width
//   SDP_PIPE_LAT   : upstream datapath latency in cycles (issue -> in_data)
//   SDP_FIFO_DEPTH : result queue depth
//   sdp_tag_t      : 2-bit arrival sequence number
//   sdp_entry_t    : queue entry {tag, data}
package sdp_pkg;

    localparam int unsigned SDP_DATA_W     = 8;
    localparam int unsigned SDP_PIPE_LAT   = 3;
    localparam int unsigned SDP_FIFO_DEPTH = 4;
    localparam int unsigned SDP_PTR_W      = 2;
    localparam int unsigned SDP_CNT_W      = 3;

    typedef logic [1:0]            sdp_tag_t;
    typedef logic [SDP_DATA_W-1:0] sdp_data_t;

    typedef struct packed {
        sdp_tag_t  tag;
        sdp_data_t data;
    } sdp_entry_t;

endpackage

// File: rtl/sdp_result_collector_if.sv
// Result output handshake of the SDP result collector.
//   out_valid : head-of-queue result present
//   out_ready : consumer accepts the head this cycle
//   out_data  : head result
//   out_tag   : arrival sequence number of the head, mod 4
// Modports: master (collector side), slave (consumer side).
interface sdp_result_collector_if;
    import sdp_pkg::*;

    logic      out_valid;
    logic      out_ready;
    sdp_data_t out_data;
    sdp_tag_t  out_tag;

    modport master (output out_valid, output out_data, output out_tag, input out_ready);
    modport slave  (input out_valid, input out_data, input out_tag, output out_ready);

endinterface

// File: rtl/sdp_fifo4.sv
// Four-entry result queue with 2-bit wrapping pointers.
//   clk, reset : clock, synchronous active-high reset
//   push       : write wr_data (accepted when not full, or when popping)
//   pop        : remove the head (ignored when empty)
//   wr_data    : entry to write
//   rd_data    : head entry (combinational)
//   count      : occupancy 0..4
module sdp_fifo4
    import sdp_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  sdp_entry_t           wr_data,
    output sdp_entry_t           rd_data,
    output logic [SDP_CNT_W-1:0] count
);

    sdp_entry_t           mem [SDP_FIFO_DEPTH];
    logic [SDP_PTR_W-1:0] wr_ptr;
    logic [SDP_PTR_W-1:0] rd_ptr;
    logic                 empty;
    logic                 full;
    logic                 do_push;
    logic                 do_pop;

    always_comb begin
        empty   = (count == '0);
        full    = (count == SDP_CNT_W'(SDP_FIFO_DEPTH));
        do_pop  = pop && !empty;
        // A full queue still accepts a push when the head leaves in the same cycle.
        do_push = push && (!full || do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/sdp_result_collector.sv
// Collects results from the 3-stage SDP datapath into a 4-entry tagged queue.
//   clk, reset : clock, synchronous active-high reset
//   in_issue   : upstream accepted an operand set this cycle
//   in_data    : registered upstream result
//   out_if     : result handshake (out_valid/out_ready/out_data/out_tag)
//   count      : queue occupancy 0..4
//   overflow   : sticky, a result was dropped on a full queue
//   csum       : running checksum of popped data (only with SDP_COLLECT_CSUM_EN)
// Optional feature macro: SDP_COLLECT_CSUM_EN.
module sdp_result_collector
    import sdp_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_issue,
    input  sdp_data_t              in_data,
    sdp_result_collector_if.master out_if,
    output logic [SDP_CNT_W-1:0]   count,
    output logic                   overflow
`ifdef SDP_COLLECT_CSUM_EN
    ,
    output sdp_data_t              csum
`endif
);

    logic [SDP_PIPE_LAT-1:0] vsr;
    logic                    marked;
    logic                    pop;
    logic                    drop;
    sdp_tag_t                tag_cnt;
    sdp_entry_t              head;

    always_comb begin
        // Top bit of the tracker lines up with in_data of the matching issue.
        marked = vsr[SDP_PIPE_LAT-1];
        pop    = out_if.out_valid && out_if.out_ready;
        drop   = marked && (count == SDP_CNT_W'(SDP_FIFO_DEPTH)) && !pop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vsr      <= '0;
            tag_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            vsr <= {vsr[SDP_PIPE_LAT-2:0], in_issue};
            // Tag advances even on a drop so the consumer sees the gap.
            if (marked) tag_cnt  <= tag_cnt + 1'b1;
            if (drop)   overflow <= 1'b1;
        end
    end

    sdp_fifo4 u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (marked),
        .pop     (pop),
        .wr_data ('{tag: tag_cnt, data: in_data}),
        .rd_data (head),
        .count   (count)
    );

    assign out_if.out_valid = (count != '0);
    assign out_if.out_data  = head.data;
    assign out_if.out_tag   = head.tag;

`ifdef SDP_COLLECT_CSUM_EN
    always_ff @(posedge clk) begin
        if (reset)
            csum <= '0;
        else if (pop)
            csum <= csum + out_if.out_data;
    end
`endif

endmodule

// File: tb/tb_sdp_result_collector.sv
// Self-checking bench for sdp_result_collector: directed scenarios plus a
// randomized phase, every cycle compared against a queue-based reference model.
module tb_sdp_result_collector;
    import sdp_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_issue;
    logic [7:0] in_data;
    logic [2:0] count;
    logic       overflow;
`ifdef SDP_COLLECT_CSUM_EN
    logic [7:0] csum;
`endif

    sdp_result_collector_if bus ();

    sdp_result_collector dut (
        .clk      (clk),
        .reset    (reset),
        .in_issue (in_issue),
        .in_data  (in_data),
        .out_if   (bus),
        .count    (count),
        .overflow (overflow)
`ifdef SDP_COLLECT_CSUM_EN
        ,
        .csum     (csum)
`endif
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;

    // Reference model: issue cycles in flight, queued {tag,data}, tag, flags.
    int         issues [$];
    logic [9:0] mq [$];
    int         m_tag  = 0;
    bit         m_ovf  = 1'b0;
    logic [7:0] m_csum = 8'h00;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        chk("valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("data", 32'(bus.out_data), 32'(mq[0][7:0]));
            chk("tag",  32'(bus.out_tag),  32'(mq[0][9:8]));
        end
        chk("count",    32'(count),    32'(mq.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef SDP_COLLECT_CSUM_EN
        chk("csum", 32'(csum), 32'(m_csum));
`endif
    endtask

    task automatic model_edge(input bit rst, input bit issue, input bit rdy, input logic [7:0] d);
        bit marked;
        logic [1:0] t2;
        marked = 1'b0;
        if (rst) begin
            issues.delete();
            mq.delete();
            m_tag  = 0;
            m_ovf  = 1'b0;
            m_csum = 8'h00;
        end else begin
            while (issues.size() != 0 && issues[0] < cyc - 3) void'(issues.pop_front());
            if (issues.size() != 0 && issues[0] == cyc - 3) begin
                marked = 1'b1;
                void'(issues.pop_front());
            end
            if (mq.size() != 0 && rdy) begin
                m_csum = m_csum + mq[0][7:0];
                void'(mq.pop_front());
            end
            if (marked) begin
                t2 = 2'(m_tag);
                if (mq.size() < 4) mq.push_back({t2, d});
                else               m_ovf = 1'b1;
                m_tag = (m_tag + 1) % 4;
            end
            if (issue) issues.push_back(cyc);
        end
    endtask

    task automatic step(input bit rst, input bit issue, input bit rdy, input logic [7:0] d);
        reset         = rst;
        in_issue      = issue;
        bus.out_ready = rdy;
        in_data       = d;
        check_outputs();
        model_edge(rst, issue, rdy, d);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [7:0] rnd8();
        return 8'($urandom);
    endfunction

    logic [7:0] vals [5];
    logic [7:0] d;

    initial begin
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        reset = 1'b1; in_issue = 1'b0; bus.out_ready = 1'b0; in_data = 8'h00;
        @(posedge clk);
        #1;

        // Reset state and single issue at cycle 10 with result 5A at cycle 13.
        step(1, 0, 0, rnd8());
        step(1, 0, 0, rnd8());
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        while (cyc < 10) step(0, 0, 1, rnd8());
        step(0, 1, 1, rnd8());
        step(0, 0, 1, rnd8());
        step(0, 0, 1, rnd8());
        chk("single_early_valid", 32'(bus.out_valid), 32'd0);
        step(0, 0, 1, 8'h5A);
        chk("single_valid_c14", 32'(bus.out_valid), 32'd1);
        chk("single_data", 32'(bus.out_data), 32'h5A);
        chk("single_tag", 32'(bus.out_tag), 32'd0);
        step(0, 0, 1, rnd8());
        chk("single_valid_c15", 32'(bus.out_valid), 32'd0);

        // Five issues into a stalled queue: the fifth is dropped.
        step(1, 0, 0, rnd8());
        for (int j = 0; j < 9; j++) begin
            d = rnd8();
            if (j >= 3 && j <= 7) d = vals[j-3];
            step(0, j < 5, 0, d);
        end
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_pop_tag", 32'(bus.out_tag), 32'(i));
            chk("ovf_pop_data", 32'(bus.out_data), 32'(vals[i]));
            step(0, 0, 1, rnd8());
        end
        chk("ovf_empty", 32'(bus.out_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Full queue with push and pop in the same cycle.
        step(1, 0, 0, rnd8());
        for (int j = 0; j < 8; j++) begin
            d = rnd8();
            if (j >= 3) d = vals[j-3];
            if (j == 7) begin
                chk("pp_count_before", 32'(count), 32'd4);
                chk("pp_head_tag", 32'(bus.out_tag), 32'd0);
            end
            step(0, j < 5, j == 7, d);
        end
        chk("pp_count_after", 32'(count), 32'd4);
        chk("pp_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("pp_tag", 32'(bus.out_tag), 32'((i + 1) % 4));
            chk("pp_data", 32'(bus.out_data), 32'(vals[i+1]));
            step(0, 0, 1, rnd8());
        end

        // Reset two cycles after an issue discards it; tags restart at 0.
        step(1, 0, 0, rnd8());
        step(0, 1, 0, rnd8());
        step(0, 0, 0, rnd8());
        step(1, 0, 0, rnd8());
        for (int j = 0; j < 6; j++) begin
            chk("rst_flight_valid", 32'(bus.out_valid), 32'd0);
            step(0, 0, 0, rnd8());
        end
        step(0, 1, 0, rnd8());
        step(0, 0, 0, rnd8());
        step(0, 0, 0, rnd8());
        step(0, 0, 0, 8'h77);
        chk("rst_tag_restart", 32'(bus.out_tag), 32'd0);
        chk("rst_data_after", 32'(bus.out_data), 32'h77);
        step(0, 0, 1, rnd8());

        // Back-to-back issues with a ready consumer: one result per cycle.
        for (int j = 0; j < 24; j++) step(0, j < 20, 1, rnd8());
        chk("b2b_no_overflow", 32'(overflow), 32'd0);
        chk("b2b_drained", 32'(count), 32'd0);

        // Randomized traffic with occasional reset.
        for (int j = 0; j < 500; j++)
            step($urandom_range(0, 79) == 0, 1'($urandom), $urandom_range(0, 3) != 0, rnd8());

`ifdef SDP_COLLECT_CSUM_EN
        // Checksum wrap: F0 + 20 = 10 mod 256.
        step(1, 0, 0, rnd8());
        step(0, 1, 1, rnd8());
        step(0, 1, 1, rnd8());
        step(0, 0, 1, rnd8());
        step(0, 0, 1, 8'hF0);
        step(0, 0, 1, 8'h20);
        step(0, 0, 1, rnd8());
        step(0, 0, 1, rnd8());
        chk("csum_wrap", 32'(csum), 32'h10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
